// File: rtl/alu_pkg.sv
// Shared ALU constants: default datapath width, requester IDs, and the
// output-register state encoding used by addsub_arbiter.
package alu_pkg;

  localparam int WIDTH_DEF = 64;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // The response register is either empty or holding one result.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

endpackage : alu_pkg

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit add/subtract: result = a + (sub ? ~b : b) + sub,
// with carry-out (1 = no borrow on subtract) and two's-complement overflow.
module addsub_core #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   sum;

  assign b_x = sub ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub};

  assign result = sum[WIDTH-1:0];
  assign carry  = sum[WIDTH];

  // Overflow: both addends share a sign and the result's sign differs.
  assign overflow = (a[WIDTH-1] == b_x[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);

endmodule : addsub_core

// File: rtl/addsub_arbiter.sv
// Two-requester arbiter sharing one add/sub datapath with a single registered,
// backpressured response. Define ADDSUB_ARB_RR_EN for round-robin tie-break;
// otherwise requester 0 wins every tie.
//
// Handshake: a request transfers on an edge where reqN_valid && reqN_ready;
// the response is consumed on an edge where rsp_valid && rsp_ready. Requesters
// keep valid and operands stable until ready; readies never depend on operands.
module addsub_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_overflow
);

  rsp_state_e       state_q, state_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic             any_valid;
  logic             tie_winner;
  logic             grant;
  logic             can_accept;
  logic             xfer;

  logic [WIDTH-1:0] mux_a, mux_b;
  logic             mux_sub;
  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_ovf;

  // ---------------------------------------------------------------- arbiter
  assign any_valid = req0_valid || req1_valid;

`ifdef ADDSUB_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (xfer) begin
      last_grant_d = grant;
    end
  end

  // Reset to REQ1 so the first tie after reset goes to requester 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= REQ1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign tie_winner = ~last_grant_q;
`else
  assign tie_winner = REQ0;
`endif

  always_comb begin
    grant = REQ0;
    if (req0_valid && !req1_valid) begin
      grant = REQ0;
    end else if (req1_valid && !req0_valid) begin
      grant = REQ1;
    end else if (req0_valid && req1_valid) begin
      grant = tie_winner;
    end
  end

  assign can_accept = (state_q == ST_EMPTY) || rsp_ready;

  // rst_n gates the readies so nothing is accepted while reset is applied.
  assign req0_ready = rst_n && can_accept && req0_valid && (grant == REQ0);
  assign req1_ready = rst_n && can_accept && req1_valid && (grant == REQ1);
  assign xfer       = rst_n && can_accept && any_valid;

  // -------------------------------------------------------- grant mux + core
  always_comb begin
    mux_a   = req0_a;
    mux_b   = req0_b;
    mux_sub = req0_sub;
    if (grant == REQ1) begin
      mux_a   = req1_a;
      mux_b   = req1_b;
      mux_sub = req1_sub;
    end
  end

  addsub_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a        (mux_a),
    .b        (mux_b),
    .sub      (mux_sub),
    .result   (core_result),
    .carry    (core_carry),
    .overflow (core_ovf)
  );

  // --------------------------------------------------------- output register
  always_comb begin
    state_d  = state_q;
    rsp_id_d = rsp_id_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_EMPTY: begin
        if (xfer) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (xfer) begin
          state_d = ST_FULL;
        end else if (rsp_ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (xfer) begin
      rsp_id_d = grant;
      result_d = core_result;
      carry_d  = core_carry;
      ovf_d    = core_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      rsp_id_q <= REQ0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rsp_id_q <= rsp_id_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign rsp_valid    = (state_q == ST_FULL);
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = result_q;
  assign rsp_carry    = carry_q;
  assign rsp_overflow = ovf_q;

endmodule : addsub_arbiter

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: single-requester add/sub, overflow and
// carry corners, tie arbitration, backpressure and mid-stream reset.
module tb_addsub_arbiter;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_sub;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_sub;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_overflow;
  logic [W-1:0] rsp_result;

  int checks;
  int failures;

  addsub_arbiter #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_sub     (req0_sub),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_sub     (req1_sub),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow)
  );

  // ------------------------------------------------------ clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------ driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    req0_valid = v;
    req0_a     = a;
    req0_b     = b;
    req0_sub   = s;
  endtask

  task automatic drive1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    req1_valid = v;
    req1_a     = a;
    req1_b     = b;
    req1_sub   = s;
  endtask

  // -------------------------------------------------------------- comparators
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic id,
                         input logic [W-1:0] res, input logic c, input logic o);
    chk1({tag, "_valid"}, rsp_valid, v);
    chk1({tag, "_id"}, rsp_id, id);
    chkw({tag, "_result"}, rsp_result, res);
    chk1({tag, "_carry"}, rsp_carry, c);
    chk1({tag, "_ovf"}, rsp_overflow, o);
  endtask

  // ------------------------------------------------------------- main sequence
  logic         exp_tie [4];
  logic [W-1:0] exp_res;

  initial begin
    checks   = 0;
    failures = 0;
`ifdef ADDSUB_ARB_RR_EN
    exp_tie[0] = 1'b0; exp_tie[1] = 1'b1; exp_tie[2] = 1'b0; exp_tie[3] = 1'b1;
`else
    exp_tie[0] = 1'b0; exp_tie[1] = 1'b0; exp_tie[2] = 1'b0; exp_tie[3] = 1'b0;
`endif

    // Reset with a pending request: nothing must be accepted.
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    drive0(1'b1, 64'd1, 64'd1, 1'b0);
    drive1(1'b0, '0, '0, 1'b0);
    step();
    step();
    #1;
    chk1("rst_ready0", req0_ready, 1'b0);
    chk_rsp("rst", 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    drive0(1'b0, '0, '0, 1'b0);
    rst_n = 1'b1;
    step();

    // req0 subtract with borrow.
    drive0(1'b1, 64'd738468, 64'd900000, 1'b1);
    #1;
    chk1("sub0_ready0", req0_ready, 1'b1);
    chk1("sub0_ready1", req1_ready, 1'b0);
    step();
    chk_rsp("sub0", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFD_8904, 1'b0, 1'b0);

    // req1 subtract without borrow; previous result drains at the same edge.
    drive0(1'b0, '0, '0, 1'b0);
    drive1(1'b1, 64'd7446525, 64'd1000000, 1'b1);
    #1;
    chk1("sub1_ready1", req1_ready, 1'b1);
    step();
    chk_rsp("sub1", 1'b1, 1'b1, 64'd6446525, 1'b1, 1'b0);

    // Signed overflow on add.
    drive1(1'b0, '0, '0, 1'b0);
    drive0(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    step();
    chk_rsp("add_ovf", 1'b1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);

    // Signed overflow on subtract.
    drive0(1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
    step();
    chk_rsp("sub_ovf", 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Unsigned wrap on add from req1 (also leaves last grant on requester 1).
    drive0(1'b0, '0, '0, 1'b0);
    drive1(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    step();
    chk_rsp("add_wrap", 1'b1, 1'b1, 64'd0, 1'b1, 1'b0);

    // Both valid for four cycles with the consumer always ready.
    for (int k = 0; k < 4; k++) begin
      drive0(1'b1, 64'(100 + k), 64'd1, 1'b0);
      drive1(1'b1, 64'(200 + k), 64'd2, 1'b0);
      #1;
      chk1($sformatf("tie%0d_ready0", k), req0_ready, exp_tie[k] == 1'b0);
      chk1($sformatf("tie%0d_ready1", k), req1_ready, exp_tie[k] == 1'b1);
      step();
      exp_res = (exp_tie[k] == 1'b0) ? 64'(101 + k) : 64'(202 + k);
      chk1($sformatf("tie%0d_valid", k), rsp_valid, 1'b1);
      chk1($sformatf("tie%0d_id", k), rsp_id, exp_tie[k]);
      chkw($sformatf("tie%0d_result", k), rsp_result, exp_res);
    end

    // Drain to empty.
    drive0(1'b0, '0, '0, 1'b0);
    drive1(1'b0, '0, '0, 1'b0);
    step();
    chk1("drain_valid", rsp_valid, 1'b0);

    // Backpressure: fill, then stall three cycles with req1 waiting.
    rsp_ready = 1'b0;
    drive0(1'b1, 64'd5, 64'd3, 1'b0);
    #1;
    chk1("fill_ready0", req0_ready, 1'b1);
    step();
    chk_rsp("fill", 1'b1, 1'b0, 64'd8, 1'b0, 1'b0);
    drive0(1'b0, '0, '0, 1'b0);
    drive1(1'b1, 64'd50, 64'd20, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1($sformatf("stall%0d_ready0", k), req0_ready, 1'b0);
      chk1($sformatf("stall%0d_ready1", k), req1_ready, 1'b0);
      step();
      chk_rsp($sformatf("stall%0d", k), 1'b1, 1'b0, 64'd8, 1'b0, 1'b0);
    end
    rsp_ready = 1'b1;
    #1;
    chk1("release_ready1", req1_ready, 1'b1);
    step();
    chk_rsp("release", 1'b1, 1'b1, 64'd30, 1'b1, 1'b0);

    // Reset while FULL discards the held result.
    drive1(1'b0, '0, '0, 1'b0);
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    step();
    chk_rsp("mid_rst", 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;

    // First tie after reset goes to requester 0.
    drive0(1'b1, 64'd10, 64'd4, 1'b1);
    drive1(1'b1, 64'd20, 64'd4, 1'b1);
    #1;
    chk1("post_rst_ready0", req0_ready, 1'b1);
    chk1("post_rst_ready1", req1_ready, 1'b0);
    step();
    chk_rsp("post_rst", 1'b1, 1'b0, 64'd6, 1'b1, 1'b0);
    drive0(1'b0, '0, '0, 1'b0);
    drive1(1'b0, '0, '0, 1'b0);
    step();
    chk1("final_empty", rsp_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_addsub_arbiter
